// File: rtl/hex_display_sequencer_pkg.sv
// Shared definitions for the hex display sequencer: FSM states, ASCII anchors
// and word geometry.
package hex_display_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] ASCII_0 = 8'h30;
   localparam logic [7:0] ASCII_A = 8'h41;

   localparam int NIBBLES = 8;
   localparam int WORD_W  = 32;

endpackage

// File: rtl/hex_display_sequencer_if.sv
// Bundle of the request side (debug taps) and the text-buffer write port.
// The master modport is the sequencer's view; slave is the environment's view.
interface hex_display_sequencer_if #(
   parameter int NREQ   = 4,
   parameter int ADDR_W = 5
);

   logic [NREQ-1:0]        req;
   logic [NREQ*32-1:0]     data;
   logic [NREQ*ADDR_W-1:0] base_addr;
   logic [NREQ-1:0]        ack;
   logic                   busy;
   logic                   wr_en;
   logic [ADDR_W-1:0]      wr_addr;
   logic [7:0]             wr_char;
   logic                   wr_ready;

   modport master (
      input  req, data, base_addr, wr_ready,
      output ack, busy, wr_en, wr_addr, wr_char
   );

   modport slave (
      output req, data, base_addr, wr_ready,
      input  ack, busy, wr_en, wr_addr, wr_char
   );

endinterface

// File: rtl/hex_nibble_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex digit.
module hex_nibble_ascii
   import hex_display_sequencer_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [7:0] o_ascii
);

   // Digits map onto '0'..'9', letters onto 'A'..'F'
   always_comb begin
      if (i_nibble < 4'd10) begin
         o_ascii = ASCII_0 + {4'd0, i_nibble};
      end else begin
         o_ascii = ASCII_A + ({4'd0, i_nibble} - 8'd10);
      end
   end

endmodule

// File: rtl/hex_display_sequencer.sv
// Round-robin sequencer that shares one nibble converter between several debug
// taps and writes each granted 32-bit word as 8 hex characters, MSB first.
module hex_display_sequencer
   import hex_display_sequencer_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int ADDR_W = 5
)
(
   input logic                     clk,
   input logic                     rst,
   hex_display_sequencer_if.master bus
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t              r_state, w_stateNext;
   logic [PTR_W-1:0]    r_ptr, w_ptrNext;
   logic [PTR_W-1:0]    r_grant, w_grantNext;
   logic [WORD_W-1:0]   r_data, w_dataNext;
   logic [2:0]          r_nibCnt, w_nibCntNext;
   logic [NREQ-1:0]     r_ack, w_ackNext;
   logic                r_busy, w_busyNext;
   logic                r_wrEn, w_wrEnNext;
   logic [ADDR_W-1:0]   r_wrAddr, w_wrAddrNext;
   logic [7:0]          r_wrChar, w_wrCharNext;

   logic                w_found;
   logic [PTR_W-1:0]    w_pick;
   logic [WORD_W-1:0]   w_selData;
   logic [ADDR_W-1:0]   w_selBase;
   logic [3:0]          w_nibble;
   logic [7:0]          w_ascii;
   logic                w_accept;

   assign w_accept = r_wrEn && bus.wr_ready;

   // In IDLE the first character comes straight from the selected source; while
   // emitting, r_data is shifted left so bits [27:24] always hold the next nibble.
   assign w_nibble = (r_state == ST_IDLE) ? w_selData[31:28] : r_data[27:24];

   hex_nibble_ascii u_nibbleAscii (
      .i_nibble (w_nibble),
      .o_ascii  (w_ascii)
   );

   // Rotated priority scan: first requesting source at or after the pointer
   always_comb begin
      logic [PTR_W:0] sum;
      sum     = '0;
      w_found = 1'b0;
      w_pick  = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
         if (sum >= (PTR_W+1)'(NREQ)) begin
            sum = sum - (PTR_W+1)'(NREQ);
         end
         if (!w_found && bus.req[sum[PTR_W-1:0]]) begin
            w_found = 1'b1;
            w_pick  = sum[PTR_W-1:0];
         end
      end
   end

   // Pick out the winning source's word and first cell address
   always_comb begin
      w_selData = '0;
      w_selBase = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_pick == PTR_W'(i)) begin
            w_selData = bus.data[32*i +: 32];
            w_selBase = bus.base_addr[ADDR_W*i +: ADDR_W];
         end
      end
   end

   // Next-state and next-output logic; ack is only ever raised for one cycle
   always_comb begin
      w_stateNext  = r_state;
      w_ptrNext    = r_ptr;
      w_grantNext  = r_grant;
      w_dataNext   = r_data;
      w_nibCntNext = r_nibCnt;
      w_ackNext    = '0;
      w_busyNext   = r_busy;
      w_wrEnNext   = r_wrEn;
      w_wrAddrNext = r_wrAddr;
      w_wrCharNext = r_wrChar;
      case (r_state)
         ST_IDLE: begin
            w_busyNext = 1'b0;
            w_wrEnNext = 1'b0;
            if (w_found) begin
               w_grantNext  = w_pick;
               w_dataNext   = w_selData;
               w_nibCntNext = 3'd0;
               w_wrEnNext   = 1'b1;
               w_wrAddrNext = w_selBase;
               w_wrCharNext = w_ascii;
               w_busyNext   = 1'b1;
               w_stateNext  = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (w_accept) begin
               if (r_nibCnt == 3'(NIBBLES-1)) begin
                  w_wrEnNext         = 1'b0;
                  w_busyNext         = 1'b0;
                  w_ackNext[r_grant] = 1'b1;
                  w_stateNext        = ST_DONE;
               end else begin
                  w_nibCntNext = r_nibCnt + 3'd1;
                  w_wrAddrNext = r_wrAddr + ADDR_W'(1);
                  w_wrCharNext = w_ascii;
                  w_dataNext   = r_data << 4;
               end
            end
         end
         ST_DONE: begin
            w_ptrNext   = (r_grant == PTR_W'(NREQ-1)) ? '0 : r_grant + PTR_W'(1);
            w_stateNext = ST_IDLE;
         end
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any word in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_ptr    <= '0;
         r_grant  <= '0;
         r_data   <= '0;
         r_nibCnt <= '0;
         r_ack    <= '0;
         r_busy   <= 1'b0;
         r_wrEn   <= 1'b0;
         r_wrAddr <= '0;
         r_wrChar <= 8'h00;
      end else begin
         r_state  <= w_stateNext;
         r_ptr    <= w_ptrNext;
         r_grant  <= w_grantNext;
         r_data   <= w_dataNext;
         r_nibCnt <= w_nibCntNext;
         r_ack    <= w_ackNext;
         r_busy   <= w_busyNext;
         r_wrEn   <= w_wrEnNext;
         r_wrAddr <= w_wrAddrNext;
         r_wrChar <= w_wrCharNext;
      end
   end

   assign bus.ack     = r_ack;
   assign bus.busy    = r_busy;
   assign bus.wr_en   = r_wrEn;
   assign bus.wr_addr = r_wrAddr;
   assign bus.wr_char = r_wrChar;

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Bench for hex_display_sequencer: a transaction-level model predicts every
// cycle's outputs, directed scenarios pin specific literal results, and a
// randomized phase stresses arbitration, back-pressure and reset.
module tb_hex_display_sequencer;

   localparam int NREQ   = 4;
   localparam int ADDR_W = 5;

   logic clk = 1'b0;
   logic rst;

   hex_display_sequencer_if #(.NREQ(NREQ), .ADDR_W(ADDR_W)) bus ();

   hex_display_sequencer #(.NREQ(NREQ), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   logic [31:0]       srcData [NREQ];
   logic [ADDR_W-1:0] srcBase [NREQ];

   // Pack per-source words and bases onto the flat bus fields
   always_comb begin
      bus.data      = '0;
      bus.base_addr = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.data[32*i +: 32]              = srcData[i];
         bus.base_addr[ADDR_W*i +: ADDR_W] = srcBase[i];
      end
   end

   // Model: mPhase 0 = idle, 1..8 = presenting character k, 9 = ack cycle
   int          mPtr   = 0;
   int          mPhase = 0;
   int          mGrant = 0;
   int          mBase  = 0;
   logic [31:0] mWord  = '0;
   bit          mFresh = 1'b1;

   // Logs of what the DUT actually did, for the directed literal checks
   int   logAddr[$];
   int   logChar[$];
   int   logAck[$];
   int   firstWrCyc = -1;
   int   ackCyc     = -1;
   logic prevWrEn   = 1'b0;

   function automatic logic [7:0] asciiOf(int v);
      if (v < 10) return 8'(48 + v);
      return 8'(65 + v - 10);
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Model advance: looks only at the inputs seen at the clock edge
   always @(posedge clk) begin
      int s;
      cyc++;
      if (rst) begin
         mPtr   = 0;
         mPhase = 0;
         mFresh = 1'b1;
      end else if (mPhase == 0) begin
         for (int k = 0; k < NREQ; k++) begin
            s = (mPtr + k) % NREQ;
            if (mPhase == 0 && ((bus.req >> s) & 1) != 0) begin
               mGrant = s;
               mWord  = srcData[s];
               mBase  = int'(srcBase[s]);
               mPhase = 1;
               mFresh = 1'b0;
            end
         end
      end else if (mPhase <= 8) begin
         if (bus.wr_ready) mPhase++;
      end else begin
         mPtr   = (mGrant + 1) % NREQ;
         mPhase = 0;
      end
   end

   // Compare DUT against the model every cycle, half a period after the edge
   always @(negedge clk) begin
      bit expWrEn;
      int nib;
      if (cyc > 0) begin
         expWrEn = (mPhase >= 1 && mPhase <= 8);
         checkOutput("wr_en", 32'(bus.wr_en), 32'(expWrEn));
         checkOutput("busy",  32'(bus.busy),  32'(expWrEn));
         checkOutput("ack",   32'(bus.ack),   (mPhase == 9) ? (32'd1 << mGrant) : 32'd0);
         if (expWrEn) begin
            nib = int'((mWord >> (4 * (8 - mPhase))) & 32'hF);
            checkOutput("wr_addr", 32'(bus.wr_addr), 32'((mBase + mPhase - 1) % 32));
            checkOutput("wr_char", 32'(bus.wr_char), 32'(asciiOf(nib)));
         end else if (mFresh) begin
            checkOutput("wr_addr_rst", 32'(bus.wr_addr), 32'd0);
            checkOutput("wr_char_rst", 32'(bus.wr_char), 32'd0);
         end
         if (bus.wr_en && bus.wr_ready) begin
            logAddr.push_back(int'(bus.wr_addr));
            logChar.push_back(int'(bus.wr_char));
         end
         if (bus.wr_en && !prevWrEn) firstWrCyc = cyc;
         prevWrEn = bus.wr_en;
         if (bus.ack != '0) begin
            ackCyc = cyc;
            for (int i = 0; i < NREQ; i++) if (bus.ack[i]) logAck.push_back(i);
         end
      end
   end

   task automatic stepCycle(int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic applyStimulus(int src, logic [31:0] word, logic [ADDR_W-1:0] base);
      srcData[src] = word;
      srcBase[src] = base;
   endtask

   task automatic clearLogs();
      logAddr.delete();
      logChar.delete();
      logAck.delete();
      firstWrCyc = -1;
      ackCyc     = -1;
   endtask

   // Wait (bounded) for an ack pulse; returns in the following IDLE cycle
   task automatic waitAck(output int src);
      int n;
      n   = 0;
      src = -1;
      while (src < 0 && n < 200) begin
         @(negedge clk);
         n++;
         for (int i = 0; i < NREQ; i++) if (bus.ack[i]) src = i;
      end
      @(posedge clk);
      #2;
      if (src < 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL ack_timeout: got no ack, expected one within 200 cycles");
      end
   endtask

   logic [7:0]        t1Chars [8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44};
   logic [7:0]        t2Chars [8] = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
   logic [ADDR_W-1:0] t2Addrs [8] = '{5'd28, 5'd29, 5'd30, 5'd31, 5'd0, 5'd1, 5'd2, 5'd3};
   int                t3Order [4] = '{0, 1, 3, 0};

   initial begin
      int src;
      rst          = 1'b1;
      bus.req      = '0;
      bus.wr_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) applyStimulus(i, 32'h0, '0);
      stepCycle(3);
      rst = 1'b0;
      stepCycle(2);

      // Round-robin order with held requests, then source 0 re-requests
      applyStimulus(0, 32'h01234567, 5'd0);
      applyStimulus(1, 32'h89ABCDEF, 5'd8);
      applyStimulus(2, 32'h55555555, 5'd16);
      applyStimulus(3, 32'hFEDCBA98, 5'd24);
      clearLogs();
      bus.req = 4'b1011;
      for (int n = 0; n < 4; n++) begin
         waitAck(src);
         if (src >= 0) bus.req[src] = 1'b0;
         if (n == 2) bus.req[0] = 1'b1;
      end
      bus.req = '0;
      checkOutput("t3_ack_count", 32'(logAck.size()), 32'd4);
      for (int i = 0; i < 4 && i < logAck.size(); i++)
         checkOutput("t3_grant_order", 32'(logAck[i]), 32'(t3Order[i]));
      stepCycle(2);

      // Basic word at base 0
      applyStimulus(0, 32'h1234ABCD, 5'd0);
      clearLogs();
      bus.req = 4'b0001;
      waitAck(src);
      bus.req = '0;
      checkOutput("t1_ack_src", 32'(src), 32'd0);
      checkOutput("t1_writes", 32'(logAddr.size()), 32'd8);
      for (int i = 0; i < 8 && i < logAddr.size(); i++) begin
         checkOutput("t1_addr", 32'(logAddr[i]), 32'(i));
         checkOutput("t1_char", 32'(logChar[i]), 32'(t1Chars[i]));
      end
      checkOutput("t1_ack_latency", 32'(ackCyc - firstWrCyc), 32'd8);
      stepCycle(2);

      // Address wrap from base 28
      applyStimulus(2, 32'hDEADBEEF, 5'd28);
      clearLogs();
      bus.req = 4'b0100;
      waitAck(src);
      bus.req = '0;
      checkOutput("t2_writes", 32'(logAddr.size()), 32'd8);
      for (int i = 0; i < 8 && i < logAddr.size(); i++) begin
         checkOutput("t2_addr", 32'(logAddr[i]), 32'(t2Addrs[i]));
         checkOutput("t2_char", 32'(logChar[i]), 32'(t2Chars[i]));
      end
      stepCycle(2);

      // Source data changing after the grant is ignored
      applyStimulus(0, 32'h00000000, 5'd0);
      clearLogs();
      bus.req = 4'b0001;
      stepCycle(1);
      srcData[0] = 32'hFFFFFFFF;
      waitAck(src);
      bus.req = '0;
      checkOutput("t5_writes", 32'(logChar.size()), 32'd8);
      for (int i = 0; i < logChar.size(); i++)
         checkOutput("t5_char", 32'(logChar[i]), 32'h30);
      stepCycle(2);

      // Three-cycle stall while the third character is presented
      applyStimulus(1, 32'h0F1E2D3C, 5'd10);
      clearLogs();
      bus.req = 4'b0010;
      stepCycle(3);
      bus.wr_ready = 1'b0;
      stepCycle(3);
      bus.wr_ready = 1'b1;
      waitAck(src);
      bus.req = '0;
      checkOutput("t4_writes", 32'(logAddr.size()), 32'd8);
      checkOutput("t4_ack_latency", 32'(ackCyc - firstWrCyc), 32'd11);
      stepCycle(2);

      // Reset during the fifth write, then fresh arbitration from pointer 0
      applyStimulus(2, 32'hCAFE0123, 5'd20);
      applyStimulus(1, 32'h89ABCDEF, 5'd4);
      bus.req = 4'b0100;
      stepCycle(5);
      rst     = 1'b1;
      bus.req = 4'b0110;
      stepCycle(1);
      checkOutput("t6_wr_en", 32'(bus.wr_en), 32'd0);
      checkOutput("t6_busy",  32'(bus.busy),  32'd0);
      checkOutput("t6_ack",   32'(bus.ack),   32'd0);
      rst = 1'b0;
      clearLogs();
      waitAck(src);
      bus.req = '0;
      checkOutput("t6_ack_src", 32'(src), 32'd1);
      checkOutput("t6_writes", 32'(logAddr.size()), 32'd8);
      if (logAddr.size() > 0) begin
         checkOutput("t6_first_addr", 32'(logAddr[0]), 32'd4);
         checkOutput("t6_first_char", 32'(logChar[0]), 32'h38);
      end
      stepCycle(2);

      // Randomized traffic, back-pressure and occasional reset
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 3) == 0) bus.req = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) applyStimulus(i, $urandom, ADDR_W'($urandom));
         bus.wr_ready = ($urandom_range(0, 3) != 0);
         rst          = ($urandom_range(0, 149) == 0);
         stepCycle(1);
      end
      rst          = 1'b0;
      bus.req      = '0;
      bus.wr_ready = 1'b1;
      stepCycle(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
